// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath: IR/Stop in, strobes out.
// master = sequencer side, slave = datapath side.
interface control_sequencer_if;
   logic [31:0] IR;
   logic        Stop;
   logic        PCout, Zlowout, Zhighout, MDRout;
   logic        MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, LOin, HIin;
   logic        IncPC, Read;
   logic [15:0] Rout, Rin;
   logic [4:0]  operation;
   logic        Run;

   modport master (
      input  IR, Stop,
      output PCout, Zlowout, Zhighout, MDRout,
      output MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, LOin, HIin,
      output IncPC, Read, Rout, Rin, operation, Run
   );

   modport slave (
      output IR, Stop,
      input  PCout, Zlowout, Zhighout, MDRout,
      input  MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, LOin, HIin,
      input  IncPC, Read, Rout, Rin, operation, Run
   );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer for a bus-based CPU: fetch in T0-T2, class decode in T3,
// execute in T4-T6, with pause (STOPPED) and absorbing HALT.
module control_sequencer (
   input  logic               Clock,
   input  logic               Reset,
   control_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      RESET_ST, T0, T1, T2, T3, T4, T5, T6, STOPPED, HALT
   } state_t;

   state_t      state, next_state;
   logic [4:0]  opcode;
   logic        is_alu, is_muldiv, is_halt;
   logic [15:0] ra_sel, rb_sel, rc_sel;

   assign opcode    = bus.IR[31:27];
   assign is_alu    = (opcode >= 5'b00011) && (opcode <= 5'b01011);
   assign is_muldiv = (opcode == 5'b01110) || (opcode == 5'b01111);
   assign is_halt   = (opcode == 5'b11011);
   assign ra_sel    = 16'd1 << bus.IR[26:23];
   assign rb_sel    = 16'd1 << bus.IR[22:19];
   assign rc_sel    = 16'd1 << bus.IR[18:15];

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)
         state <= RESET_ST;
      else
         state <= next_state;
   end

   // Outputs depend only on the registered state and the current IR, so an
   // asynchronous reset clears every strobe in the same instant.
   always_comb begin
      next_state    = state;
      bus.PCout     = 1'b0;
      bus.Zlowout   = 1'b0;
      bus.Zhighout  = 1'b0;
      bus.MDRout    = 1'b0;
      bus.MARin     = 1'b0;
      bus.PCin      = 1'b0;
      bus.MDRin     = 1'b0;
      bus.IRin      = 1'b0;
      bus.Yin       = 1'b0;
      bus.Zlowin    = 1'b0;
      bus.Zhighin   = 1'b0;
      bus.LOin      = 1'b0;
      bus.HIin      = 1'b0;
      bus.IncPC     = 1'b0;
      bus.Read      = 1'b0;
      bus.Rout      = 16'h0000;
      bus.Rin       = 16'h0000;
      bus.operation = 5'b00000;
      bus.Run       = 1'b1;

      case (state)
         RESET_ST: begin
            bus.Run    = 1'b0;
            next_state = T0;
         end
         T0: begin
            bus.PCout  = 1'b1;
            bus.MARin  = 1'b1;
            bus.IncPC  = 1'b1;
            bus.Zlowin = 1'b1;
            next_state = T1;
         end
         T1: begin
            bus.Zlowout = 1'b1;
            bus.PCin    = 1'b1;
            bus.Read    = 1'b1;
            bus.MDRin   = 1'b1;
            next_state  = T2;
         end
         T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
            next_state = T3;
         end
         T3: begin
            if (is_alu || is_muldiv) begin
               bus.Rout   = rb_sel;
               bus.Yin    = 1'b1;
               next_state = T4;
            end else if (is_halt) begin
               next_state = HALT;
            end else begin
               next_state = bus.Stop ? STOPPED : T0;
            end
         end
         T4: begin
            bus.Rout      = rc_sel;
            bus.Zlowin    = 1'b1;
            bus.Zhighin   = is_muldiv;
            bus.operation = opcode;
            next_state    = T5;
         end
         T5: begin
            bus.Zlowout = 1'b1;
            if (is_muldiv) begin
               bus.LOin   = 1'b1;
               next_state = T6;
            end else begin
               bus.Rin    = ra_sel;
               next_state = bus.Stop ? STOPPED : T0;
            end
         end
         T6: begin
            bus.Zhighout = 1'b1;
            bus.HIin     = 1'b1;
            next_state   = bus.Stop ? STOPPED : T0;
         end
         STOPPED: begin
            bus.Run    = 1'b0;
            next_state = bus.Stop ? STOPPED : T0;
         end
         HALT: begin
            bus.Run    = 1'b0;
            next_state = HALT;
         end
         default: begin
            bus.Run    = 1'b0;
            next_state = RESET_ST;
         end
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks add, div, NOP, HALT, Stop and
// mid-instruction reset scenarios against hand-computed strobe patterns.
module tb_control_sequencer;

   logic Clock;
   logic Reset;
   int   vectors;
   int   miscompares;

   control_sequencer_if bus_if ();

   control_sequencer dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus_if.master)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Flag order: PCout Zlowout Zhighout MDRout MARin PCin MDRin IRin Yin Zlowin Zhighin LOin HIin IncPC Read
   localparam logic [14:0] F_PCOUT    = 15'h4000;
   localparam logic [14:0] F_ZLOWOUT  = 15'h2000;
   localparam logic [14:0] F_ZHIGHOUT = 15'h1000;
   localparam logic [14:0] F_MDROUT   = 15'h0800;
   localparam logic [14:0] F_MARIN    = 15'h0400;
   localparam logic [14:0] F_PCIN     = 15'h0200;
   localparam logic [14:0] F_MDRIN    = 15'h0100;
   localparam logic [14:0] F_IRIN     = 15'h0080;
   localparam logic [14:0] F_YIN      = 15'h0040;
   localparam logic [14:0] F_ZLOWIN   = 15'h0020;
   localparam logic [14:0] F_ZHIGHIN  = 15'h0010;
   localparam logic [14:0] F_LOIN     = 15'h0008;
   localparam logic [14:0] F_HIIN     = 15'h0004;
   localparam logic [14:0] F_INCPC    = 15'h0002;
   localparam logic [14:0] F_READ     = 15'h0001;

   localparam logic [14:0] EXP_T0 = F_PCOUT | F_MARIN | F_INCPC | F_ZLOWIN;
   localparam logic [14:0] EXP_T1 = F_ZLOWOUT | F_PCIN | F_READ | F_MDRIN;
   localparam logic [14:0] EXP_T2 = F_MDROUT | F_IRIN;

   task automatic checkOutput(input string tag, input logic [14:0] exp_flags,
                              input logic [15:0] exp_rout, input logic [15:0] exp_rin,
                              input logic [4:0] exp_op, input logic exp_run);
      logic [52:0] observed, expected;
      observed = {bus_if.PCout, bus_if.Zlowout, bus_if.Zhighout, bus_if.MDRout,
                  bus_if.MARin, bus_if.PCin, bus_if.MDRin, bus_if.IRin, bus_if.Yin,
                  bus_if.Zlowin, bus_if.Zhighin, bus_if.LOin, bus_if.HIin,
                  bus_if.IncPC, bus_if.Read, bus_if.Rout, bus_if.Rin,
                  bus_if.operation, bus_if.Run};
      expected = {exp_flags, exp_rout, exp_rin, exp_op, exp_run};
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   // Runs T0-T2, presents the new instruction during T2 and leaves the bench in T3.
   task automatic fetch(input string name, input logic [31:0] next_ir);
      applyStimulus();
      checkOutput({name, "_T0"}, EXP_T0, 16'h0, 16'h0, 5'd0, 1'b1);
      applyStimulus();
      checkOutput({name, "_T1"}, EXP_T1, 16'h0, 16'h0, 5'd0, 1'b1);
      applyStimulus();
      checkOutput({name, "_T2"}, EXP_T2, 16'h0, 16'h0, 5'd0, 1'b1);
      bus_if.IR = next_ir;
      applyStimulus();
   endtask

   // Structural invariants sampled every cycle away from the clock edge.
   always @(negedge Clock) begin
      logic [4:0] drivers;
      drivers = {bus_if.PCout, bus_if.Zlowout, bus_if.Zhighout, bus_if.MDRout, |bus_if.Rout};
      vectors++;
      assert ($onehot0(drivers))
      else begin
         miscompares++;
         $error("[TB] FAIL bus_exclusive observed=%b expected=at most one bit", drivers);
      end
      vectors++;
      assert ($onehot0(bus_if.Rout) && $onehot0(bus_if.Rin))
      else begin
         miscompares++;
         $error("[TB] FAIL reg_onehot observed Rout=%h Rin=%h expected=one-hot or zero",
                bus_if.Rout, bus_if.Rin);
      end
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      Reset       = 1'b1;
      bus_if.Stop = 1'b0;
      bus_if.IR   = 32'h0;

      @(negedge Clock);
      checkOutput("reset_state", 15'h0, 16'h0, 16'h0, 5'd0, 1'b0);
      Reset = 1'b0;

      // and R4,R5,R7
      fetch("and", 32'h2A2B8000);
      checkOutput("and_T3", F_YIN, 16'h0020, 16'h0, 5'd0, 1'b1);
      applyStimulus();
      checkOutput("and_T4", F_ZLOWIN, 16'h0080, 16'h0, 5'b00101, 1'b1);
      applyStimulus();
      checkOutput("and_T5", F_ZLOWOUT, 16'h0, 16'h0010, 5'd0, 1'b1);

      // div with this encoding decodes as Ra=R2, Rb=R6, Rc=R0
      fetch("div", 32'h79300000);
      checkOutput("div_T3", F_YIN, 16'h0040, 16'h0, 5'd0, 1'b1);
      applyStimulus();
      checkOutput("div_T4", F_ZLOWIN | F_ZHIGHIN, 16'h0001, 16'h0, 5'b01111, 1'b1);
      applyStimulus();
      checkOutput("div_T5", F_ZLOWOUT | F_LOIN, 16'h0, 16'h0, 5'd0, 1'b1);
      applyStimulus();
      checkOutput("div_T6", F_ZHIGHOUT | F_HIIN, 16'h0, 16'h0, 5'd0, 1'b1);

      fetch("nop", 32'hD0000000);
      checkOutput("nop_T3", 15'h0, 16'h0, 16'h0, 5'd0, 1'b1);

      fetch("halt", 32'hD8000000);
      checkOutput("halt_T3", 15'h0, 16'h0, 16'h0, 5'd0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         applyStimulus();
         checkOutput("halt_hold", 15'h0, 16'h0, 16'h0, 5'd0, 1'b0);
      end
      Reset = 1'b1;
      #1;
      checkOutput("halt_reset", 15'h0, 16'h0, 16'h0, 5'd0, 1'b0);
      @(negedge Clock);
      Reset = 1'b0;

      // add R1,R2,R3 with Stop raised mid-execution
      fetch("add", 32'h18918000);
      checkOutput("add_T3", F_YIN, 16'h0004, 16'h0, 5'd0, 1'b1);
      applyStimulus();
      checkOutput("add_T4", F_ZLOWIN, 16'h0008, 16'h0, 5'b00011, 1'b1);
      bus_if.Stop = 1'b1;
      applyStimulus();
      checkOutput("add_T5_stop", F_ZLOWOUT, 16'h0, 16'h0002, 5'd0, 1'b1);
      applyStimulus();
      checkOutput("stopped_1", 15'h0, 16'h0, 16'h0, 5'd0, 1'b0);
      applyStimulus();
      checkOutput("stopped_2", 15'h0, 16'h0, 16'h0, 5'd0, 1'b0);
      bus_if.Stop = 1'b0;

      // mul R0,R2,R6 interrupted by an asynchronous reset in T6
      fetch("mul", 32'h70130000);
      checkOutput("mul_T3", F_YIN, 16'h0004, 16'h0, 5'd0, 1'b1);
      applyStimulus();
      checkOutput("mul_T4", F_ZLOWIN | F_ZHIGHIN, 16'h0040, 16'h0, 5'b01110, 1'b1);
      applyStimulus();
      checkOutput("mul_T5", F_ZLOWOUT | F_LOIN, 16'h0, 16'h0, 5'd0, 1'b1);
      applyStimulus();
      checkOutput("mul_T6", F_ZHIGHOUT | F_HIIN, 16'h0, 16'h0, 5'd0, 1'b1);
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("mul_async_reset", 15'h0, 16'h0, 16'h0, 5'd0, 1'b0);
      @(negedge Clock);
      checkOutput("reset_held", 15'h0, 16'h0, 16'h0, 5'd0, 1'b0);
      Reset = 1'b0;
      applyStimulus();
      checkOutput("restart_T0", EXP_T0, 16'h0, 16'h0, 5'd0, 1'b1);
      applyStimulus();
      checkOutput("restart_T1", EXP_T1, 16'h0, 16'h0, 5'd0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
